// File: rtl/i2c_bus_conditioner.sv
// I2C pad front end: synchronises and glitch-filters SCL/SDA, emits registered edge, START/STOP and bus-busy.
// Optional SCL-low bus timeout is compiled in when I2C_BUS_TIMEOUT_EN is defined.
module i2c_bus_conditioner #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic rstart_det,
    output logic stop_det,
    output logic bus_busy,
    output logic bus_timeout
);

    localparam int FCW = $clog2(FILTER_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic [FCW-1:0]         scl_cnt;
    logic [FCW-1:0]         sda_cnt;
    logic [FCW-1:0]         scl_cnt_nxt;
    logic [FCW-1:0]         sda_cnt_nxt;
    logic                   scl_nxt;
    logic                   sda_nxt;
    logic                   start_ev;
    logic                   stop_ev;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

    // A line flips only after FILTER_CYCLES consecutive samples disagree with the held level.
    always_comb begin
        scl_nxt     = scl_f;
        scl_cnt_nxt = '0;
        if (scl_sync[SYNC_STAGES-1] != scl_f) begin
            if (scl_cnt == FCW'(FILTER_CYCLES - 1)) begin
                scl_nxt = scl_sync[SYNC_STAGES-1];
            end else begin
                scl_cnt_nxt = scl_cnt + FCW'(1);
            end
        end
    end

    always_comb begin
        sda_nxt     = sda_f;
        sda_cnt_nxt = '0;
        if (sda_sync[SYNC_STAGES-1] != sda_f) begin
            if (sda_cnt == FCW'(FILTER_CYCLES - 1)) begin
                sda_nxt = sda_sync[SYNC_STAGES-1];
            end else begin
                sda_cnt_nxt = sda_cnt + FCW'(1);
            end
        end
    end

    // SCL must be steady high across the SDA change; a coincident SCL edge suppresses START/STOP.
    assign start_ev = scl_f & scl_nxt & sda_f & ~sda_nxt;
    assign stop_ev  = scl_f & scl_nxt & ~sda_f & sda_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_f      <= 1'b1;
            sda_f      <= 1'b1;
            scl_cnt    <= '0;
            sda_cnt    <= '0;
            scl_rise   <= 1'b0;
            scl_fall   <= 1'b0;
            start_det  <= 1'b0;
            rstart_det <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            scl_f      <= scl_nxt;
            sda_f      <= sda_nxt;
            scl_cnt    <= scl_cnt_nxt;
            sda_cnt    <= sda_cnt_nxt;
            scl_rise   <= scl_nxt & ~scl_f;
            scl_fall   <= ~scl_nxt & scl_f;
            start_det  <= start_ev;
            rstart_det <= start_ev & (state == BUSY);
            stop_det   <= stop_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_det) state_nxt = BUSY;
            BUSY:    if (stop_det || bus_timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus_busy = (state == BUSY);

`ifdef I2C_BUS_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || (state != BUSY) || scl_f) begin
            tmo_cnt     <= '0;
            bus_timeout <= 1'b0;
        end else if (tmo_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt     <= '0;
            bus_timeout <= 1'b1;
        end else begin
            tmo_cnt     <= tmo_cnt + TCW'(1);
            bus_timeout <= 1'b0;
        end
    end
`else
    assign bus_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Bench for i2c_bus_conditioner: directed bus scenarios plus random pad activity, every cycle
// compared against a window-based behavioural model of filter, events and bus state.
module tb_i2c_bus_conditioner;

    localparam int S = 2;
    localparam int F = 3;
    localparam int T = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_i = 1'b1;
    logic sda_i = 1'b1;
    logic scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det, stop_det, bus_busy, bus_timeout;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    int c_rise = 0, c_fall = 0, c_start = 0, c_rstart = 0, c_stop = 0, c_tmo = 0;

    always #5 clk = ~clk;

    i2c_bus_conditioner #(
        .SYNC_STAGES   (S),
        .FILTER_CYCLES (F),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_f      (scl_f),
        .sda_f      (sda_f),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .start_det  (start_det),
        .rstart_det (rstart_det),
        .stop_det   (stop_det),
        .bus_busy   (bus_busy),
        .bus_timeout(bus_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: pad history delayed S cycles, level flips when the last F delayed samples
    // all disagree with it; events from old/new levels; bus state follows the previous cycle's events.
    bit m_scl_dly[S];
    bit m_sda_dly[S];
    bit scl_win[$];
    bit sda_win[$];
    bit m_scl = 1, m_sda = 1, m_rise, m_fall, m_start, m_rstart, m_stop, m_busy, m_tmo;
    int m_tc = 0;

    function automatic bit all_disagree(input bit w[$], input bit lvl);
        if (w.size() < F) return 1'b0;
        foreach (w[i]) if (w[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit s_scl, s_sda, n_scl, n_sda, n_busy, n_tmo;
        if (rst) begin
            foreach (m_scl_dly[i]) begin
                m_scl_dly[i] = 1'b1;
                m_sda_dly[i] = 1'b1;
            end
            scl_win.delete();
            sda_win.delete();
            m_scl = 1; m_sda = 1;
            m_rise = 0; m_fall = 0; m_start = 0; m_rstart = 0; m_stop = 0; m_tmo = 0;
            m_busy = 0; m_tc = 0;
        end else begin
            s_scl = m_scl_dly[S-1];
            s_sda = m_sda_dly[S-1];
            for (int i = S - 1; i > 0; i--) begin
                m_scl_dly[i] = m_scl_dly[i-1];
                m_sda_dly[i] = m_sda_dly[i-1];
            end
            m_scl_dly[0] = scl_i;
            m_sda_dly[0] = sda_i;
            scl_win.push_back(s_scl);
            sda_win.push_back(s_sda);
            if (scl_win.size() > F) void'(scl_win.pop_front());
            if (sda_win.size() > F) void'(sda_win.pop_front());
            n_scl  = all_disagree(scl_win, m_scl) ? ~m_scl : m_scl;
            n_sda  = all_disagree(sda_win, m_sda) ? ~m_sda : m_sda;
            n_busy = m_busy ? ~(m_stop | m_tmo) : m_start;
            n_tmo  = 0;
`ifdef I2C_BUS_TIMEOUT_EN
            if (!m_busy || m_scl) m_tc = 0;
            else begin
                m_tc++;
                if (m_tc == T) begin
                    n_tmo = 1;
                    m_tc  = 0;
                end
            end
`endif
            m_rise   = n_scl & ~m_scl;
            m_fall   = ~n_scl & m_scl;
            m_start  = m_scl & n_scl & m_sda & ~n_sda;
            m_stop   = m_scl & n_scl & ~m_sda & n_sda;
            m_rstart = m_start & m_busy;
            m_tmo    = n_tmo;
            m_busy   = n_busy;
            m_scl    = n_scl;
            m_sda    = n_sda;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("outputs",
                     {23'd0, scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det, stop_det, bus_busy, bus_timeout},
                     {23'd0, m_scl, m_sda, m_rise, m_fall, m_start, m_rstart, m_stop, m_busy, m_tmo});
            c_rise   += int'(scl_rise);
            c_fall   += int'(scl_fall);
            c_start  += int'(start_det);
            c_rstart += int'(rstart_det);
            c_stop   += int'(stop_det);
            c_tmo    += int'(bus_timeout);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_scl(input bit v);
        scl_i = v;
        cyc(8);
    endtask

    task automatic set_sda(input bit v);
        sda_i = v;
        cyc(8);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 8; i >= 0; i--) begin
            set_sda(bits[i]);
            set_scl(1'b1);
            set_scl(1'b0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0, f0, s0, rs0, p0, t0, hit;
        int unsigned act;

        rst = 1'b1;
        cyc(2);
        check_eq("rst_levels", {scl_f, sda_f}, 2'b11);
        check_eq("rst_pulses", {scl_rise, scl_fall, start_det, rstart_det, stop_det, bus_busy, bus_timeout}, 7'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc(4);

        // START: pad change after edge 0 must show on edge S+F
        sda_i = 1'b0;
        cyc(S + F - 1);
        check_eq("start_early_sda_f", sda_f, 1'b1);
        cyc(1);
        check_eq("start_sda_f", sda_f, 1'b0);
        check_eq("start_det", start_det, 1'b1);
        check_eq("start_rstart", rstart_det, 1'b0);
        check_eq("start_busy_same", bus_busy, 1'b0);
        cyc(1);
        check_eq("start_busy_next", bus_busy, 1'b1);
        check_eq("start_pulse_end", start_det, 1'b0);
        set_sda(1'b1);
        check_eq("stop_busy", bus_busy, 1'b0);

        // Two-cycle glitch on SDA must be absorbed
        s0 = c_start;
        sda_i = 1'b0;
        cyc(2);
        sda_i = 1'b1;
        cyc(10);
        check_eq("glitch_sda_f", sda_f, 1'b1);
        check_eq("glitch_start", c_start - s0, 0);
        check_eq("glitch_busy", bus_busy, 1'b0);

        // Full transaction: START, 0x50+W+ACK, repeated START, 0x50+R+ACK, STOP
        r0 = c_rise; f0 = c_fall; s0 = c_start; rs0 = c_rstart; p0 = c_stop;
        set_sda(1'b0);
        set_scl(1'b0);
        send_byte(8'hA0);
        set_sda(1'b1);
        set_scl(1'b1);
        set_sda(1'b0);
        set_scl(1'b0);
        send_byte(8'hA1);
        set_sda(1'b0);
        set_scl(1'b1);
        check_eq("txn_busy_mid", bus_busy, 1'b1);
        set_sda(1'b1);
        // 18 data clocks, plus the SCL rise before the repeated START and the one before STOP;
        // falls: one after each START and one per data clock
        check_eq("txn_rise", c_rise - r0, 18 + 2);
        check_eq("txn_fall", c_fall - f0, 18 + 2);
        check_eq("txn_start", c_start - s0, 2);
        check_eq("txn_rstart", c_rstart - rs0, 1);
        check_eq("txn_stop", c_stop - p0, 1);
        check_eq("txn_busy_end", bus_busy, 1'b0);

        // Simultaneous SCL/SDA fall while idle
        f0 = c_fall; s0 = c_start;
        scl_i = 1'b0;
        sda_i = 1'b0;
        cyc(10);
        check_eq("simul_fall", c_fall - f0, 1);
        check_eq("simul_start", c_start - s0, 0);
        check_eq("simul_busy", bus_busy, 1'b0);
        set_scl(1'b1);
        set_sda(1'b1);
        check_eq("idle_stop_busy", bus_busy, 1'b0);

        // SCL held low after START
        t0 = c_tmo;
        set_sda(1'b0);
        scl_i = 1'b0;
        hit = -1;
`ifdef I2C_BUS_TIMEOUT_EN
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (bus_timeout) begin
                hit = i + 1;
                break;
            end
        end
        check_eq("tmo_edge", hit, S + F + T);
        cyc(1);
        check_eq("tmo_busy_after", bus_busy, 1'b0);
        check_eq("tmo_pulse_end", bus_timeout, 1'b0);
`else
        cyc(300);
        check_eq("notmo_busy", bus_busy, 1'b1);
        check_eq("notmo_pulses", c_tmo - t0, 0);
`endif
        set_scl(1'b1);
        set_sda(1'b1);
        check_eq("tmo_release_busy", bus_busy, 1'b0);

        // Reset in the middle of a transaction with both pads low
        set_sda(1'b0);
        set_scl(1'b0);
        check_eq("mid_busy_pre", bus_busy, 1'b1);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        check_eq("mid_rst_levels", {scl_f, sda_f, bus_busy}, 3'b110);
        f0 = c_fall; s0 = c_start;
        cyc(8);
        check_eq("mid_scl_f", {scl_f, sda_f}, 2'b00);
        check_eq("mid_fall", c_fall - f0, 1);
        check_eq("mid_start", c_start - s0, 0);
        check_eq("mid_busy", bus_busy, 1'b0);
        set_scl(1'b1);
        set_sda(1'b1);

        // Random pad activity, short holds produce glitches, coincident edges and resets
        for (int it = 0; it < 2500; it++) begin
            act = $urandom_range(0, 63);
            if (act == 0) begin
                rst = 1'b1;
                cyc(int'($urandom_range(1, 2)));
                rst = 1'b0;
            end else if (act < 28) begin
                scl_i = ~scl_i;
            end else if (act < 56) begin
                sda_i = ~sda_i;
            end else begin
                scl_i = ~scl_i;
                sda_i = ~sda_i;
            end
            cyc(int'($urandom_range(1, 10)));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
